// File: rtl/pc_source_ctrl.sv
// PC-source mux sequencer: resolves PC update requests and drives the mux selector and PC/EPC write enables.
// Exception handling (EPC save, vector fetch, handler load) is present only when PCSRC_EXC_EN is defined.
module pc_source_ctrl #(
    parameter int unsigned MEM_LAT    = 1,
    parameter logic [7:0]  VEC_OPCODE = 8'd253,
    parameter logic [7:0]  VEC_OVF    = 8'd254,
    parameter logic [7:0]  VEC_DIV0   = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_inc,
    input  logic        req_branch,
    input  logic        br_cond,
    input  logic        req_jump,
    input  logic        req_jr,
    input  logic        req_rte,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    output logic [2:0]  pc_source,
    output logic        pc_write,
    output logic        epc_write,
    output logic [31:0] vec_addr,
    output logic        vec_sel,
    output logic [1:0]  exc_cause,
    output logic        busy
);

    logic        win_valid;
    logic [2:0]  win_src;
    logic [2:0]  pc_source_nxt;
    logic        pc_write_nxt;
    logic        epc_write_nxt;
    logic [31:0] vec_addr_nxt;
    logic        vec_sel_nxt;
    logic [1:0]  exc_cause_nxt;
    logic        busy_nxt;

    // Non-exception priority: a false branch still wins and suppresses lower requests.
    always_comb begin
        win_valid = 1'b0;
        win_src   = 3'd0;
        if (req_rte) begin
            win_valid = 1'b1;
            win_src   = 3'd4;
        end else if (req_jr) begin
            win_valid = 1'b1;
            win_src   = 3'd3;
        end else if (req_jump) begin
            win_valid = 1'b1;
            win_src   = 3'd2;
        end else if (req_branch) begin
            win_valid = br_cond;
            win_src   = br_cond ? 3'd1 : 3'd0;
        end else if (req_inc) begin
            win_valid = 1'b1;
            win_src   = 3'd0;
        end else begin
            win_valid = 1'b0;
            win_src   = 3'd0;
        end
    end

`ifdef PCSRC_EXC_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXC_SAVE = 2'd1,
        EXC_WAIT = 2'd2,
        EXC_LOAD = 2'd3
    } state_t;

    localparam logic [2:0] LAT = MEM_LAT[2:0];

    state_t     state_r;
    state_t     next_state;
    logic [2:0] cnt_r;
    logic       exc_any;
    logic [1:0] exc_code;
    logic [7:0] exc_vec;

    assign exc_any = exc_opcode | exc_ovf | exc_div0;

    // Exception cause and vector selection by fixed priority
    always_comb begin
        if (exc_opcode) begin
            exc_code = 2'd1;
            exc_vec  = VEC_OPCODE;
        end else if (exc_ovf) begin
            exc_code = 2'd2;
            exc_vec  = VEC_OVF;
        end else if (exc_div0) begin
            exc_code = 2'd3;
            exc_vec  = VEC_DIV0;
        end else begin
            exc_code = 2'd0;
            exc_vec  = 8'd0;
        end
    end

    // State register and memory-latency counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= next_state;
            if (state_r == EXC_SAVE) begin
                cnt_r <= LAT;
            end else if (state_r == EXC_WAIT) begin
                cnt_r <= cnt_r - 3'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state_r;
        case (state_r)
            IDLE:     next_state = exc_any ? EXC_SAVE : IDLE;
            EXC_SAVE: next_state = EXC_WAIT;
            EXC_WAIT: next_state = (cnt_r == 3'd1) ? EXC_LOAD : EXC_WAIT;
            EXC_LOAD: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output values for the next cycle; cause and vector hold until the next exception
    always_comb begin
        pc_source_nxt = 3'd0;
        pc_write_nxt  = 1'b0;
        epc_write_nxt = 1'b0;
        vec_sel_nxt   = 1'b0;
        busy_nxt      = 1'b0;
        vec_addr_nxt  = vec_addr;
        exc_cause_nxt = exc_cause;
        case (state_r)
            IDLE: begin
                if (exc_any) begin
                    epc_write_nxt = 1'b1;
                    vec_sel_nxt   = 1'b1;
                    busy_nxt      = 1'b1;
                    vec_addr_nxt  = {24'd0, exc_vec};
                    exc_cause_nxt = exc_code;
                end else begin
                    pc_write_nxt  = win_valid;
                    pc_source_nxt = win_src;
                end
            end
            EXC_SAVE: begin
                vec_sel_nxt = 1'b1;
                busy_nxt    = 1'b1;
            end
            EXC_WAIT: begin
                vec_sel_nxt = 1'b1;
                busy_nxt    = 1'b1;
                if (cnt_r == 3'd1) begin
                    pc_source_nxt = 3'd5;
                    pc_write_nxt  = 1'b1;
                end else begin
                    pc_source_nxt = 3'd0;
                    pc_write_nxt  = 1'b0;
                end
            end
            EXC_LOAD: begin
                pc_write_nxt = 1'b0;
            end
            default: begin
                pc_write_nxt = 1'b0;
            end
        endcase
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, exc_opcode, exc_ovf, exc_div0, MEM_LAT, VEC_OPCODE, VEC_OVF, VEC_DIV0};

    // Without exceptions the block is a single-state request decoder
    always_comb begin
        pc_write_nxt  = win_valid;
        pc_source_nxt = win_src;
        epc_write_nxt = 1'b0;
        vec_sel_nxt   = 1'b0;
        busy_nxt      = 1'b0;
        vec_addr_nxt  = 32'd0;
        exc_cause_nxt = 2'd0;
    end
`endif

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_source <= 3'd0;
            pc_write  <= 1'b0;
            epc_write <= 1'b0;
            vec_addr  <= 32'd0;
            vec_sel   <= 1'b0;
            exc_cause <= 2'd0;
            busy      <= 1'b0;
        end else begin
            pc_source <= pc_source_nxt;
            pc_write  <= pc_write_nxt;
            epc_write <= epc_write_nxt;
            vec_addr  <= vec_addr_nxt;
            vec_sel   <= vec_sel_nxt;
            exc_cause <= exc_cause_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: doc/pc_source_ctrl.md
# pc_source_ctrl

Sequencer for the processor's six-way PC-source multiplexer. Accepts one-cycle update requests from the main control unit (sequential increment, branch, jump, jump-register, return-from-exception, exceptions), resolves priority, and drives the mux selector plus the PC/EPC write enables. Exceptions run as a multi-cycle sequence: save EPC, fetch the handler vector byte from memory, then load PC. The block sits between the control FSM and the PC register / PC-source mux.

## Interface
Parameters:
- MEM_LAT, default 1: memory read latency in cycles, from vec_addr valid to vector data valid on mux input 5; legal range 1..7.
- VEC_OPCODE, default 8'd253: memory byte address of the invalid-opcode vector.
- VEC_OVF, default 8'd254: memory byte address of the overflow vector.
- VEC_DIV0, default 8'd255: memory byte address of the divide-by-zero vector.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: clock, all state updates on rising edge.
- reset, input, 1: synchronous active-high reset.
- req_inc, input, 1: PC ← PC+4 (mux input 0).
- req_branch, input, 1: conditional branch (mux input 1).
- br_cond, input, 1: branch condition, qualifies req_branch.
- req_jump, input, 1: jump target (mux input 2).
- req_jr, input, 1: jump register (mux input 3).
- req_rte, input, 1: return from exception, PC ← EPC (mux input 4).
- exc_opcode, input, 1: invalid-opcode exception.
- exc_ovf, input, 1: arithmetic-overflow exception.
- exc_div0, input, 1: divide-by-zero exception.
- pc_source, output, 3: selector to the PC-source mux.
- pc_write, output, 1: PC register write enable.
- epc_write, output, 1: EPC register write enable.
- vec_addr, output, 32: zero-extended vector byte address to memory address mux.
- vec_sel, output, 1: steers memory address mux to vec_addr.
- exc_cause, output, 2: 0 none, 1 opcode, 2 overflow, 3 div0; held until next exception.
- busy, output, 1: exception sequence in progress; requests ignored.

## Operation
- States: IDLE, EXC_SAVE, EXC_WAIT, EXC_LOAD.
- IDLE: requests sampled every cycle. Priority, highest first: exc_opcode > exc_ovf > exc_div0 > req_rte > req_jr > req_jump > req_branch > req_inc. Lower-priority simultaneous requests are dropped.
- Non-exception winner: next cycle pc_write=1 for exactly one cycle, pc_source = 0/1/2/3/4 for inc/branch/jump/jr/rte; stay IDLE.
- req_branch with br_cond=0 (and no higher request): no pc_write; pc_source stays 0.
- No request: pc_write=0, pc_source=0.
- Exception winner: go to EXC_SAVE; latch exc_cause; vec_addr = {24'b0, VEC_x}.
- EXC_SAVE: epc_write=1 (EPC captures PC-4 via existing datapath), vec_sel=1, busy=1; next EXC_WAIT with counter = MEM_LAT.
- EXC_WAIT: vec_sel=1, busy=1; counter decrements; at counter==1 go to EXC_LOAD.
- EXC_LOAD: pc_source=5, pc_write=1, vec_sel=1, busy=1; next IDLE.
- Any request asserted while busy=1 is ignored, not queued.
- No combinational path from request inputs to outputs; all outputs registered.

## Timing
- Reset: state IDLE; pc_source=0, pc_write=0, epc_write=0, vec_sel=0, busy=0, vec_addr=0, exc_cause=0 after the reset edge.
- Reset asserted mid-sequence: abort on that edge, all outputs at reset values next cycle; no partial pc_write.
- Non-exception latency: request in cycle N → pc_write/pc_source valid in cycle N+1.
- Exception latency: request in cycle N → epc_write in N+1, EXC_WAIT N+2..N+1+MEM_LAT, pc_write with pc_source=5 in cycle N+2+MEM_LAT; busy high N+1..N+2+MEM_LAT; new requests accepted from cycle N+3+MEM_LAT.
- Back-to-back non-exception requests: one pc_write per cycle, each reflecting the previous cycle's winner.

## Configuration
- PCSRC_EXC_EN defined: exception inputs, exception states, epc_write, vec_addr, vec_sel, exc_cause, busy behave as above.
- Undefined: exc_* inputs ignored; FSM reduced to IDLE; epc_write, vec_sel, busy, exc_cause, vec_addr tied 0; pc_source never 5; req_rte still selects input 4.

## Test plan
- Reset then req_inc at cycle 3 → cycle 4 pc_write=1, pc_source=0; cycle 5 pc_write=0.
- req_branch=1, br_cond=0 → no pc_write; repeat with br_cond=1 → pc_write=1, pc_source=1 next cycle.
- req_jump, req_jr, req_inc together → pc_source=3, single pc_write.
- exc_ovf with MEM_LAT=1 at cycle N → epc_write N+1, pc_source=5 + pc_write N+3, vec_addr=254, exc_cause=2; req_jump at N+2 ignored.
- exc_opcode and exc_div0 together → vec_addr=253, exc_cause=1; with MEM_LAT=3, pc_write at N+5.
- reset asserted in EXC_WAIT → next cycle all outputs 0, no pc_write; subsequent req_rte → pc_source=4, pc_write=1.
